// File: rtl/data_mem_stack_unit.sv
// Byte-addressable data memory with a hardware stack, a registered read port and a sticky fault.
// The stack grows downward from MEM_BYTES toward STACK_BASE; sp == MEM_BYTES means empty.
module data_mem_stack_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STACK_BASE = 768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              fault_clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [ADDR_W:0]   sp,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned MEM_BYTES = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   SpEmpty   = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   SpStep    = (ADDR_W + 1)'(BYTES);
    // A push is legal only while sp >= STACK_BASE + BYTES.
    localparam logic [ADDR_W+1:0] PushLimit = (ADDR_W + 2)'(STACK_BASE + BYTES);

    localparam logic [2:0] OpLoad  = 3'b001;
    localparam logic [2:0] OpStore = 3'b010;
    localparam logic [2:0] OpPush  = 3'b011;
    localparam logic [2:0] OpPop   = 3'b100;

    localparam logic [1:0] CodeNone      = 2'b00;
    localparam logic [1:0] CodeMisalign  = 2'b01;
    localparam logic [1:0] CodeOverflow  = 2'b10;
    localparam logic [1:0] CodeUnderflow = 2'b11;

    if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a nonzero multiple of 8");
    end
    if (STACK_BASE % BYTES != 0 || STACK_BASE >= MEM_BYTES) begin : g_bad_stack_base
        $error("STACK_BASE must be word aligned and below MEM_BYTES");
    end

    typedef enum logic [0:0] {StClear, StFaulted} fault_state_e;

    logic [7:0]        mem_q [MEM_BYTES];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [ADDR_W:0]   sp_q, sp_d;
    fault_state_e      state_q, state_d;
    logic [1:0]        code_q, code_d;

    logic              is_load, is_store, is_push, is_pop;
    logic              misaligned, stack_full, stack_empty;
    logic              load_ok, store_ok, push_ok, pop_ok;
    logic [ADDR_W:0]   sp_dec, sp_inc;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic              fault_ev;
    logic [1:0]        fault_ev_code;

    // Operation decode and legality checks
    always_comb begin
        is_load     = op_valid && (op == OpLoad);
        is_store    = op_valid && (op == OpStore);
        is_push     = op_valid && (op == OpPush);
        is_pop      = op_valid && (op == OpPop);
        misaligned  = ((32'(address) % 32'(BYTES)) != 32'd0);
        stack_full  = ({1'b0, sp_q} < PushLimit);
        stack_empty = (sp_q == SpEmpty);
        load_ok     = is_load && !misaligned;
        store_ok    = is_store && !misaligned;
        push_ok     = is_push && !stack_full;
        pop_ok      = is_pop && !stack_empty;
        sp_dec      = sp_q - SpStep;
        sp_inc      = sp_q + SpStep;
    end

    always_comb begin
        fault_ev      = 1'b0;
        fault_ev_code = CodeNone;
        if ((is_load || is_store) && misaligned) begin
            fault_ev      = 1'b1;
            fault_ev_code = CodeMisalign;
        end else if (is_push && stack_full) begin
            fault_ev      = 1'b1;
            fault_ev_code = CodeOverflow;
        end else if (is_pop && stack_empty) begin
            fault_ev      = 1'b1;
            fault_ev_code = CodeUnderflow;
        end
    end

    // Memory port addressing; a push writes at the decremented pointer in the same edge
    always_comb begin
        wr_en   = store_ok || push_ok;
        wr_addr = push_ok ? sp_dec[ADDR_W-1:0] : address;
        rd_addr = pop_ok ? sp_q[ADDR_W-1:0] : address;
        rd_word = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            rd_word[8*b +: 8] = mem_q[rd_addr + ADDR_W'(b)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                mem_q[wr_addr + ADDR_W'(b)] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        sp_d          = sp_q;
        rdata_d       = rdata_q;
        rdata_valid_d = load_ok || pop_ok;
        if (push_ok) begin
            sp_d = sp_dec;
        end else if (pop_ok) begin
            sp_d = sp_inc;
        end
        if (load_ok || pop_ok) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q          <= SpEmpty;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            sp_q          <= sp_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Fault FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
            code_q  <= CodeNone;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Fault FSM: next state; first fault wins unless cleared in the same cycle
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StClear: begin
                if (fault_ev) begin
                    state_d = StFaulted;
                    code_d  = fault_ev_code;
                end
            end
            StFaulted: begin
                if (fault_ev && fault_clr) begin
                    code_d = fault_ev_code;
                end else if (fault_clr) begin
                    state_d = StClear;
                    code_d  = CodeNone;
                end
            end
            default: begin
                state_d = StClear;
                code_d  = CodeNone;
            end
        endcase
    end

    // Fault FSM: outputs
    always_comb begin
        fault      = (state_q == StFaulted);
        fault_code = code_q;
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign sp          = sp_q;

endmodule

// File: tb/tb_data_mem_stack_unit.sv
// Scoreboard bench for data_mem_stack_unit: random and directed ops against a byte-array model,
// plus a small directed check of a 16-bit / 256-byte configuration.
module tb_data_mem_stack_unit;

    localparam int NB = 4;
    localparam int MB = 1024;
    localparam int SB = 768;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [9:0]  address;
    logic [31:0] wdata;
    logic        fault_clr;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [10:0] sp;
    logic        fault;
    logic [1:0]  fault_code;

    logic        v16;
    logic [2:0]  op16;
    logic [7:0]  a16;
    logic [15:0] wd16;
    logic [15:0] rd16;
    logic        rv16;
    logic [8:0]  sp16;
    logic        f16;
    logic [1:0]  fc16;

    always #5 clk = ~clk;

    data_mem_stack_unit dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op         (op),
        .address    (address),
        .wdata      (wdata),
        .fault_clr  (fault_clr),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .sp         (sp),
        .fault      (fault),
        .fault_code (fault_code)
    );

    data_mem_stack_unit #(
        .DATA_W    (16),
        .ADDR_W    (8),
        .STACK_BASE(128)
    ) dut16 (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (v16),
        .op         (op16),
        .address    (a16),
        .wdata      (wd16),
        .fault_clr  (1'b0),
        .rdata      (rd16),
        .rdata_valid(rv16),
        .sp         (sp16),
        .fault      (f16),
        .fault_code (fc16)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [7:0]  mref [MB];
    int          sp_m;
    bit          f_m;
    logic [1:0]  code_m;
    logic [31:0] rd_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {mref[a+3], mref[a+2], mref[a+1], mref[a]};
    endfunction

    function automatic void ref_reset();
        sp_m   = MB;
        f_m    = 1'b0;
        code_m = 2'b00;
        rd_m   = 32'd0;
        exp_q.delete();
    endfunction

    function automatic void ref_apply(input bit v, input logic [2:0] o, input int a,
                                      input logic [31:0] d, input bit clr);
        int ev = 0;
        if (v) begin
            case (o)
                3'd1: if (a % NB != 0) ev = 1;
                      else begin
                          exp_q.push_back('{ref_word(a), cyc + 1});
                          rd_m = ref_word(a);
                      end
                3'd2: if (a % NB != 0) ev = 1;
                      else for (int b = 0; b < NB; b++) mref[a+b] = d[8*b +: 8];
                3'd3: if (sp_m - NB < SB) ev = 2;
                      else begin
                          sp_m = sp_m - NB;
                          for (int b = 0; b < NB; b++) mref[sp_m+b] = d[8*b +: 8];
                      end
                3'd4: if (sp_m == MB) ev = 3;
                      else begin
                          exp_q.push_back('{ref_word(sp_m), cyc + 1});
                          rd_m = ref_word(sp_m);
                          sp_m = sp_m + NB;
                      end
                default: ;
            endcase
        end
        if (ev != 0 && (!f_m || clr)) begin
            f_m    = 1'b1;
            code_m = 2'(ev);
        end else if (ev == 0 && clr) begin
            f_m    = 1'b0;
            code_m = 2'b00;
        end
    endfunction

    // Drive one op for one clock, then compare the architectural state
    task automatic step(input bit v, input logic [2:0] o, input int a, input logic [31:0] d,
                        input bit clr);
        op_valid  = v;
        op        = o;
        address   = a[9:0];
        wdata     = d;
        fault_clr = clr;
        ref_apply(v, o, a, d, clr);
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        fault_clr = 1'b0;
        chk("sp", 64'(sp), 64'(sp_m));
        chk("fault", 64'(fault), 64'(f_m));
        chk("fault_code", 64'(fault_code), 64'(code_m));
        chk("rdata_hold", 64'(rdata), 64'(rd_m));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        ref_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rdata_valid strobe must match the next scoreboard entry on the right cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (rdata_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rdata_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rdata", 64'(rdata), 64'(mon_e.data));
                    chk("rdata_latency", 64'(cyc), 64'(mon_e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing_rdata_valid", 64'(rdata_valid), 64'(1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sel;
        int a;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op        = 3'd0;
        address   = '0;
        wdata     = '0;
        fault_clr = 1'b0;
        v16       = 1'b0;
        op16      = 3'd0;
        a16       = '0;
        wd16      = '0;
        ref_reset();
        #12;
        chk("reset_sp", 64'(sp), 64'(1024));
        chk("reset_fault", 64'(fault), 64'(0));
        chk("reset_code", 64'(fault_code), 64'(0));
        chk("reset_rdata", 64'(rdata), 64'(0));
        chk("reset_valid", 64'(rdata_valid), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Initialise every word so later reads are defined
        for (int w = 0; w < MB / NB; w++) step(1'b1, 3'd2, w * NB, $urandom, 1'b0);

        // Store/load round trip and little-endian byte placement
        step(1'b1, 3'd2, 'h010, 32'hA1B2C3D4, 1'b0);
        step(1'b1, 3'd1, 'h010, 32'h0, 1'b0);
        chk("byte_0x010", 64'(dut.mem_q[16]), 64'(8'hD4));
        chk("byte_0x013", 64'(dut.mem_q[19]), 64'(8'hA1));
        step(1'b0, 3'd0, 0, 32'h0, 1'b0);

        // Two pushes and two pops
        step(1'b1, 3'd3, 0, 32'h11111111, 1'b0);
        chk("sp_after_push1", 64'(sp), 64'(1020));
        step(1'b1, 3'd3, 0, 32'h22222222, 1'b0);
        chk("sp_after_push2", 64'(sp), 64'(1016));
        step(1'b1, 3'd4, 0, 32'h0, 1'b0);
        step(1'b1, 3'd4, 0, 32'h0, 1'b0);
        chk("sp_after_pops", 64'(sp), 64'(1024));
        step(1'b0, 3'd0, 0, 32'h0, 1'b0);

        // Underflow after reset, then clear
        pulse_reset();
        step(1'b1, 3'd4, 0, 32'h0, 1'b0);
        chk("underflow_code", 64'(fault_code), 64'(3));
        step(1'b0, 3'd0, 0, 32'h0, 1'b1);
        chk("cleared_fault", 64'(fault), 64'(0));

        // Fill the stack to its limit, then overflow
        for (int i = 0; i < 64; i++) step(1'b1, 3'd3, 0, $urandom, 1'b0);
        chk("sp_full", 64'(sp), 64'(768));
        chk("no_fault_full", 64'(fault), 64'(0));
        step(1'b1, 3'd3, 0, 32'hDEADBEEF, 1'b0);
        chk("overflow_code", 64'(fault_code), 64'(2));
        step(1'b1, 3'd1, 764, 32'h0, 1'b1);

        // Misaligned load faults first; a later overflow must not replace the code
        step(1'b1, 3'd1, 'h013, 32'h0, 1'b0);
        chk("misalign_code", 64'(fault_code), 64'(1));
        step(1'b1, 3'd3, 0, 32'hCAFEF00D, 1'b0);
        chk("first_fault_wins", 64'(fault_code), 64'(1));
        for (int i = 0; i < 64; i++) step(1'b1, 3'd4, 0, 32'h0, 1'b0);
        step(1'b1, 3'd4, 0, 32'h0, 1'b1);
        chk("clr_vs_new_fault", 64'(fault_code), 64'(3));
        step(1'b0, 3'd0, 0, 32'h0, 1'b1);

        // Randomised mix, including illegal opcodes, op_valid=0 and stray clears
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, MB / NB - 1) * NB;
            if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, NB - 1);
            case (sel)
                0, 1:    step(1'b1, 3'd1, a, $urandom, $urandom_range(0, 7) == 0);
                2, 3:    step(1'b1, 3'd2, a, $urandom, $urandom_range(0, 7) == 0);
                4, 5:    step(1'b1, 3'd3, a, $urandom, $urandom_range(0, 7) == 0);
                6, 7:    step(1'b1, 3'd4, a, $urandom, $urandom_range(0, 7) == 0);
                8:       step(1'b1, 3'($urandom_range(5, 7)), a, $urandom, 1'b0);
                default: step(1'b0, 3'($urandom_range(1, 4)), a, $urandom, 1'b0);
            endcase
        end
        step(1'b0, 3'd0, 0, 32'h0, 1'b0);
        step(1'b0, 3'd0, 0, 32'h0, 1'b1);

        // Asynchronous reset between edges with a populated stack and a live fault
        for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 0, $urandom, 1'b0);
        step(1'b1, 3'd2, 'h021, 32'h0, 1'b0);
        chk("fault_before_reset", 64'(fault), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_sp", 64'(sp), 64'(1024));
        chk("async_reset_fault", 64'(fault), 64'(0));
        chk("async_reset_code", 64'(fault_code), 64'(0));
        ref_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 3'd1, 'h010, 32'h0, 1'b0);
        step(1'b0, 3'd0, 0, 32'h0, 1'b0);

        // 16-bit, 256-byte configuration
        v16  = 1'b1;
        op16 = 3'd3;
        wd16 = 16'hBEEF;
        @(posedge clk);
        #1;
        v16  = 1'b0;
        chk("w16_sp_push", 64'(sp16), 64'(254));
        v16  = 1'b1;
        op16 = 3'd4;
        @(posedge clk);
        #1;
        v16  = 1'b0;
        chk("w16_pop_valid", 64'(rv16), 64'(1));
        chk("w16_pop_data", 64'(rd16), 64'(16'hBEEF));
        chk("w16_sp_pop", 64'(sp16), 64'(256));
        chk("w16_fault", 64'(f16), 64'(0));
        @(posedge clk);
        #1;
        chk("w16_valid_drop", 64'(rv16), 64'(0));

        step(1'b0, 3'd0, 0, 32'h0, 1'b0);
        step(1'b0, 3'd0, 0, 32'h0, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
